// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a two-flop input synchronizer,
// mid-bit sampling, a one-cycle data_valid strobe, and a one-cycle
// frame_err strobe. A break (line held low) is absorbed until the line
// returns high, so it never starts a new reception.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] LAST_CNT = 8'(CLOCKS_PER_BIT - 1);
    localparam logic [7:0] HALF_CNT = 8'((CLOCKS_PER_BIT - 1) / 2);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_STOP       = 3'd3;
    localparam logic [2:0] S_BREAK_WAIT = 3'd4;

    logic       sync1_q, sync2_q;
    logic       rx_s;
    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Frame sequencing: start detection, mid-bit sampling, stop check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = 8'd0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = 8'd0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        // Start bit vanished by mid-bit: treat as a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 8'd0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_BREAK_WAIT: begin
                cnt_d = 8'd0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver: 8 data bits LSB first, one start bit, one stop bit, no parity.
- Sits directly downstream of the team's UART transmitter and consumes its serial line (outserial) or an external RX pin.
- Recovers each byte by mid-bit sampling and presents it on a parallel bus with a one-cycle valid strobe.
- Flags framing errors; same clock/baud convention as the transmitter: 25 MHz, 115200 bps, 217 clocks per bit.

Parameters:
- CLOCKS_PER_BIT, 217, clk cycles per serial bit; legal range 8..255; counters are 8 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  asynchronous serial line; idles high.
- data_out  output  8  last correctly framed byte; holds until the next good byte.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - data_out=8'h00, data_valid=0, frame_err=0, busy=0.
  - Both synchronizer flops=1; state=IDLE; bit counter=0; bit index=0; shift register=0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever emitted.
- Input synchronizer: serial_in passes through 2 flops. All decisions use the synced signal rx_s.
- HALF = (CLOCKS_PER_BIT-1)/2, integer division (108 at default).
- States: IDLE, START, DATA, STOP, BREAK_WAIT.
- IDLE:
  - When rx_s==0: go to START, clear count.
  - Otherwise stay.
- START:
  - count increments each cycle.
  - At count==HALF, sample rx_s.
  - rx_s==0: clear count, index=0, go to DATA.
  - rx_s==1: glitch. Go to IDLE with no output activity.
- DATA:
  - count increments 0..CLOCKS_PER_BIT-1.
  - At count==CLOCKS_PER_BIT-1 (mid-bit), shift rx_s into shift[index] and clear count.
  - If index==7, go to STOP. Otherwise index+1.
- STOP: count to CLOCKS_PER_BIT-1, then sample rx_s.
  - rx_s==1: next cycle data_out<=shift, data_valid=1 for exactly 1 cycle, go to IDLE.
  - rx_s==0: next cycle frame_err=1 for exactly 1 cycle. data_out unchanged, data_valid stays 0. Go to BREAK_WAIT.
- BREAK_WAIT:
  - Stay until rx_s==1, then go to IDLE.
  - A line held low, or a break, never retriggers reception.
- data_valid and frame_err are never high in the same cycle. Neither is ever high for more than 1 cycle.
- Latency:
  - START detection occurs 2–3 cycles after the serial_in falling edge.
  - data_valid rises HALF + 9*CLOCKS_PER_BIT + 1 cycles after START entry.
  - Bench tolerance vs. the serial_in edge is ±1 cycle.
- Back-to-back frames: a new start bit may begin right after the stop-bit period (transmitter STOP→IDLE→START).
  - The receiver is in IDLE roughly half a bit before that edge, so zero idle gap between frames is supported.
- Line-rate mismatch: up to ±4% between transmitter and receiver bit time must still receive correctly, given mid-bit sampling.
- Counters never wrap. count is cleared on every state change and on every sample point.

Test Plan:
- CLOCKS_PER_BIT=16, drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one data_valid pulse, data_out=8'hA5, frame_err=0, busy low after the frame; latency within ±1 of spec.
- Back-to-back 0x00 then 0xFF, zero idle gap -> two data_valid pulses, values 0x00 then 0xFF, separated by 10*16 ±1 cycles.
- serial_in low for 4 cycles, then high -> no data_valid, no frame_err; state returns to IDLE; next 0x3C is received correctly.
- 0x3C with stop bit driven 0, then line held low 50 cycles, then high, then 0x81 -> one frame_err pulse; data_out keeps its previous value; no reception during the low hold; then data_valid with 0x81.
- rst asserted during DATA bit 3 of 0x5A -> outputs are immediately at reset values and no valid pulse; after release, a fresh 0x5A yields data_out=0x5A.
- Loopback: transmitter (CLOCKS_PER_BIT=16) outserial -> serial_in, send 0x00, 0x55, 0xAA, 0xFF and 16 random bytes -> every byte received in order, frame_err never asserted.
